// File: rtl/branch_resolve_predict_if.sv
// Pipeline-facing signal bundle for the branch unit: IF lookup, EX resolve inputs,
// registered EX/MEM outcome and statistics.
interface branch_resolve_predict_if #(
    parameter int PC_WIDTH   = 32,
    parameter int STAT_WIDTH = 16
);
    logic [PC_WIDTH-1:0]   if_pc;
    logic                  predict_taken;
    logic                  ex_valid;
    logic [2:0]            ex_signal;
    logic                  ex_eq;
    logic                  ex_lt;
    logic                  ex_ltu;
    logic [PC_WIDTH-1:0]   ex_pc;
    logic                  ex_pred_taken;
    logic                  stall;
    logic                  branch_taken;
    logic                  mispredict;
    logic                  res_valid;
    logic [STAT_WIDTH-1:0] stat_branches;
    logic [STAT_WIDTH-1:0] stat_mispred;

    modport master (
        output if_pc, ex_valid, ex_signal, ex_eq, ex_lt, ex_ltu, ex_pc, ex_pred_taken, stall,
        input  predict_taken, branch_taken, mispredict, res_valid, stat_branches, stat_mispred
    );

    modport slave (
        input  if_pc, ex_valid, ex_signal, ex_eq, ex_lt, ex_ltu, ex_pc, ex_pred_taken, stall,
        output predict_taken, branch_taken, mispredict, res_valid, stat_branches, stat_mispred
    );
endinterface

// File: rtl/branch_resolve_predict.sv
// Branch resolution in EX plus a saturating-counter direction predictor for IF,
// with registered outcome/mispredict flags and saturating statistics.
module branch_resolve_predict #(
    parameter int ENTRIES    = 16,
    parameter int CNT_BITS   = 2,
    parameter int PC_WIDTH   = 32,
    parameter int STAT_WIDTH = 16
) (
    input logic                     clk,
    input logic                     reset,
    branch_resolve_predict_if.slave bus
);
    localparam int IDX = $clog2(ENTRIES);
    localparam logic [CNT_BITS-1:0]   CNT_INIT = CNT_BITS'((1 << (CNT_BITS - 1)) - 1);
    localparam logic [CNT_BITS-1:0]   CNT_MAX  = '1;
    localparam logic [STAT_WIDTH-1:0] STAT_MAX = '1;

    logic [CNT_BITS-1:0]   table_q [ENTRIES];
    logic [IDX-1:0]        lookup_idx;
    logic [IDX-1:0]        update_idx;
    logic                  is_branch;
    logic                  taken;
    logic                  mis;
    logic                  res_valid_q;
    logic                  branch_taken_q;
    logic                  mispredict_q;
    logic [STAT_WIDTH-1:0] stat_branches_q;
    logic [STAT_WIDTH-1:0] stat_mispred_q;
    logic                  unused_pc_bits;

    assign lookup_idx = bus.if_pc[IDX+1:2];
    assign update_idx = bus.ex_pc[IDX+1:2];
    assign unused_pc_bits = ^{bus.if_pc[PC_WIDTH-1:IDX+2], bus.if_pc[1:0],
                              bus.ex_pc[PC_WIDTH-1:IDX+2], bus.ex_pc[1:0]};

    // Lookup sees the pre-edge table; no bypass from a same-cycle update.
    assign bus.predict_taken = table_q[lookup_idx][CNT_BITS-1];

    always_comb begin
        is_branch = 1'b0;
        taken     = 1'b0;
        case (bus.ex_signal)
            3'd1: begin is_branch = 1'b1; taken =  bus.ex_eq;  end
            3'd2: begin is_branch = 1'b1; taken = !bus.ex_eq;  end
            3'd3: begin is_branch = 1'b1; taken =  bus.ex_lt;  end
            3'd4: begin is_branch = 1'b1; taken = !bus.ex_lt;  end
            3'd5: begin is_branch = 1'b1; taken =  bus.ex_ltu; end
            3'd6: begin is_branch = 1'b1; taken = !bus.ex_ltu; end
            default: begin is_branch = 1'b0; taken = 1'b0; end
        endcase
        is_branch = is_branch & bus.ex_valid;
        mis       = is_branch & (taken ^ bus.ex_pred_taken);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= CNT_INIT;
            end
        end else if (!bus.stall && is_branch) begin
            if (taken && table_q[update_idx] != CNT_MAX) begin
                table_q[update_idx] <= table_q[update_idx] + 1'b1;
            end else if (!taken && table_q[update_idx] != '0) begin
                table_q[update_idx] <= table_q[update_idx] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            res_valid_q    <= 1'b0;
            branch_taken_q <= 1'b0;
            mispredict_q   <= 1'b0;
        end else if (!bus.stall) begin
            res_valid_q    <= is_branch;
            branch_taken_q <= is_branch & taken;
            mispredict_q   <= mis;
        end
    end

    // Statistics stick at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_branches_q <= '0;
            stat_mispred_q  <= '0;
        end else if (!bus.stall && is_branch) begin
            if (stat_branches_q != STAT_MAX) begin
                stat_branches_q <= stat_branches_q + 1'b1;
            end
            if (mis && stat_mispred_q != STAT_MAX) begin
                stat_mispred_q <= stat_mispred_q + 1'b1;
            end
        end
    end

    assign bus.res_valid     = res_valid_q;
    assign bus.branch_taken  = branch_taken_q;
    assign bus.mispredict    = mispredict_q;
    assign bus.stat_branches = stat_branches_q;
    assign bus.stat_mispred  = stat_mispred_q;
endmodule

// File: tb/tb_branch_resolve_predict.sv
// Randomized and directed bench for branch_resolve_predict against a behavioural
// model of the predictor table, resolved outputs and statistics.
module tb_branch_resolve_predict;
    localparam int ENTRIES    = 16;
    localparam int CNT_BITS   = 2;
    localparam int PC_WIDTH   = 32;
    localparam int STAT_WIDTH = 8;
    localparam int CNT_TOP    = (1 << CNT_BITS) - 1;
    localparam int CNT_HALF   = 1 << (CNT_BITS - 1);
    localparam int STAT_TOP   = (1 << STAT_WIDTH) - 1;

    logic clk;
    logic reset;

    branch_resolve_predict_if #(.PC_WIDTH(PC_WIDTH), .STAT_WIDTH(STAT_WIDTH)) bus ();

    branch_resolve_predict #(
        .ENTRIES(ENTRIES), .CNT_BITS(CNT_BITS), .PC_WIDTH(PC_WIDTH), .STAT_WIDTH(STAT_WIDTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference state
    int m_cnt [ENTRIES];
    int m_rv, m_bt, m_mp;
    int m_branches, m_mispred;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int idx_of(input logic [31:0] pc);
        return int'(pc / 4) % ENTRIES;
    endfunction

    function automatic int predicted(input logic [31:0] pc);
        return (m_cnt[idx_of(pc)] >= CNT_HALF) ? 1 : 0;
    endfunction

    function automatic int direction(input int code, input int eq, input int lt, input int ltu);
        case (code)
            1: return eq;
            2: return 1 - eq;
            3: return lt;
            4: return 1 - lt;
            5: return ltu;
            6: return 1 - ltu;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) m_cnt[i] = CNT_HALF - 1;
        m_rv = 0; m_bt = 0; m_mp = 0;
        m_branches = 0; m_mispred = 0;
    endtask

    task automatic check_outputs(input string where);
        check({where, " res_valid"},     32'(bus.res_valid),     32'(m_rv));
        check({where, " branch_taken"},  32'(bus.branch_taken),  32'(m_bt));
        check({where, " mispredict"},    32'(bus.mispredict),    32'(m_mp));
        check({where, " stat_branches"}, 32'(bus.stat_branches), 32'(m_branches));
        check({where, " stat_mispred"},  32'(bus.stat_mispred),  32'(m_mispred));
    endtask

    // Called just after a falling edge; ends just after the next falling edge.
    task automatic step(input int valid, input int code, input int eq, input int lt, input int ltu,
                        input logic [31:0] ex_pc, input int pred, input int stall,
                        input logic [31:0] if_pc);
        int t, m, i;
        bus.ex_valid      = valid[0];
        bus.ex_signal     = code[2:0];
        bus.ex_eq         = eq[0];
        bus.ex_lt         = lt[0];
        bus.ex_ltu        = ltu[0];
        bus.ex_pc         = ex_pc;
        bus.ex_pred_taken = pred[0];
        bus.stall         = stall[0];
        bus.if_pc         = if_pc;
        #1;
        check("predict_pre", 32'(bus.predict_taken), 32'(predicted(if_pc)));
        if (stall == 0) begin
            if (valid != 0 && code >= 1 && code <= 6) begin
                t = direction(code, eq, lt, ltu);
                m = (t != pred) ? 1 : 0;
                m_rv = 1; m_bt = t; m_mp = m;
                i = idx_of(ex_pc);
                if (t == 1 && m_cnt[i] < CNT_TOP) m_cnt[i]++;
                if (t == 0 && m_cnt[i] > 0) m_cnt[i]--;
                if (m_branches < STAT_TOP) m_branches++;
                if (m == 1 && m_mispred < STAT_TOP) m_mispred++;
            end else begin
                m_rv = 0; m_bt = 0; m_mp = 0;
            end
        end
        @(posedge clk);
        #1;
        check_outputs("post");
        check("predict_post", 32'(bus.predict_taken), 32'(predicted(if_pc)));
        @(negedge clk);
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_outputs("reset");
        foreach (m_cnt[k]) m_cnt[k] = CNT_HALF - 1;
        bus.if_pc = 32'h0;
        #1 check("reset_pred_0", 32'(bus.predict_taken), 32'd0);
        bus.if_pc = 32'h40;
        #1 check("reset_pred_40", 32'(bus.predict_taken), 32'd0);
        bus.if_pc = 32'hFFFC;
        #1 check("reset_pred_fffc", 32'(bus.predict_taken), 32'd0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        logic [31:0] epc, ipc;
        reset = 1'b0;
        bus.ex_valid = 1'b0; bus.ex_signal = 3'd0; bus.ex_eq = 1'b0; bus.ex_lt = 1'b0;
        bus.ex_ltu = 1'b0; bus.ex_pc = '0; bus.ex_pred_taken = 1'b0; bus.stall = 1'b0;
        bus.if_pc = '0;
        model_reset();
        @(negedge clk);
        #1 check_outputs("init");
        @(negedge clk);
        reset = 1'b1;

        // every code against every flag combination
        for (int code = 0; code < 8; code++)
            for (int f = 0; f < 8; f++)
                step(1, code, f & 1, (f >> 1) & 1, (f >> 2) & 1, 32'h84, 0, 0, 32'h84);

        // training up then down at 0x100, then aliasing 0x140
        for (int n = 0; n < 3; n++) step(1, 1, 1, 0, 0, 32'h100, 0, 0, 32'h100);
        for (int n = 0; n < 3; n++) step(1, 1, 0, 0, 0, 32'h100, 1, 0, 32'h100);
        step(1, 2, 0, 0, 0, 32'h140, 0, 0, 32'h100);
        step(0, 0, 0, 0, 0, 32'h0, 0, 0, 32'h140);

        // mid-run reset with table trained, then same-cycle hazard from counter 01
        for (int n = 0; n < 3; n++) step(1, 3, 0, 1, 0, 32'h0, 0, 0, 32'h0);
        do_reset();
        step(1, 1, 1, 0, 0, 32'h200, 0, 0, 32'h200);
        check("hazard_next", 32'(bus.predict_taken), 32'd1);

        // stall with a taken branch parked on EX, then release
        for (int n = 0; n < 3; n++) step(1, 6, 0, 0, 0, 32'h300, 0, 1, 32'h300);
        step(1, 6, 0, 0, 0, 32'h300, 0, 0, 32'h300);

        // random traffic long enough to saturate the 8-bit branch count
        for (int n = 0; n < 900; n++) begin
            epc = 32'($urandom_range(0, 63)) << 2;
            ipc = ($urandom_range(0, 1) == 1) ? epc : (32'($urandom_range(0, 63)) << 2);
            if (n == 300) do_reset();
            step(($urandom_range(0, 7) != 0) ? 1 : 0, int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                 epc, int'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0) ? 1 : 0, ipc);
        end
        check("stat_saturated", 32'(bus.stat_branches), 32'(STAT_TOP));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
